// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: FSM states, special instruction
// words and the fetch-address legality check.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  // Program-end sentinel; never presented to the CPU as a live instruction.
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  // Instruction shown while the stage is not delivering live words.
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  // Byte distance between consecutive instruction words.
  localparam logic [31:0] PC_STEP   = 32'd4;

  // A fetch address is legal when word-aligned and inside the store.
  // No wrap-around: stepping past the last word lands outside the store.
  function automatic logic fetch_addr_ok(input logic [31:0] addr,
                                         input int unsigned depth);
    return (addr[1:0] == 2'b00) && (addr < 32'(depth * 4));
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word-addressed instruction store: synchronous write, combinational read.
// The fetch stage registers the read data, so the read port stays async.
module imem_array #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  // Contents are deliberately not reset so a loaded program survives reset.
  logic [31:0] mem [DEPTH];

  // Program-load write port.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the single-cycle CPU. Holds the fetch FSM,
// the fetch-address legality check and the registered outputs; the program
// is loaded into the internal store while idle.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic [31:0]              i_datain,
  output logic [31:0]              pc,
  output logic                     i_valid,
  output logic                     halted,
  output logic                     fault
);

  localparam int ADDR_W = $clog2(DEPTH);

  fetch_state_t state_reg, state_next;

  logic [31:0] pc_reg, pc_next;
  logic [31:0] data_reg, data_next;
  logic        valid_reg, valid_next;
  logic        halted_reg, halted_next;
  logic        fault_reg, fault_next;

  logic              fetch_en;
  logic [31:0]       fetch_addr;
  logic              addr_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rd_data;

  // Loads are only accepted while idle; elsewhere the store is read-only.
  assign mem_we   = (state_reg == ST_IDLE) && load_en;
  assign word_idx = fetch_addr[ADDR_W+1:2];
  assign addr_ok  = fetch_addr_ok(fetch_addr, DEPTH);

  imem_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_imem (
    .clock(clock),
    .we   (mem_we),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(word_idx),
    .rdata(rd_data)
  );

  // Decide whether a fetch happens this cycle and from where.
  // Priority in RUN: redirect > stall > sequential.
  always_comb begin
    fetch_en   = 1'b0;
    fetch_addr = pc_reg + PC_STEP;
    unique case (state_reg)
      ST_IDLE: begin
        // start is ignored in a cycle that also loads a word
        if (start && !load_en) begin
          fetch_en   = 1'b1;
          fetch_addr = RESET_PC;
        end
      end
      ST_RUN: begin
        if (redirect) begin
          fetch_en   = 1'b1;
          fetch_addr = redirect_pc;
        end else if (!stall) begin
          fetch_en   = 1'b1;
        end
      end
      default: begin
        fetch_en = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a fetch ends in FAULT, HALT or RUN; HALT and FAULT
  // never fetch, so they are terminal until reset.
  always_comb begin
    state_next = state_reg;
    if (fetch_en) begin
      if (!addr_ok) begin
        state_next = ST_FAULT;
      end else if (rd_data == HALT_WORD) begin
        state_next = ST_HALT;
      end else begin
        state_next = ST_RUN;
      end
    end
  end

  // Output next-values: hold unless a fetch happens; HALT and FAULT show
  // the offending/sentinel address with a NOP and no valid.
  always_comb begin
    pc_next     = pc_reg;
    data_next   = data_reg;
    valid_next  = valid_reg;
    halted_next = halted_reg;
    fault_next  = fault_reg;
    if (fetch_en) begin
      pc_next = fetch_addr;
      if (!addr_ok) begin
        data_next  = NOP_WORD;
        valid_next = 1'b0;
        fault_next = 1'b1;
      end else if (rd_data == HALT_WORD) begin
        data_next   = NOP_WORD;
        valid_next  = 1'b0;
        halted_next = 1'b1;
      end else begin
        data_next  = rd_data;
        valid_next = 1'b1;
      end
    end
  end

  // Output registers; reset clears them asynchronously, sticky flags included.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_reg     <= RESET_PC;
      data_reg   <= NOP_WORD;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
      fault_reg  <= 1'b0;
    end else begin
      pc_reg     <= pc_next;
      data_reg   <= data_next;
      valid_reg  <= valid_next;
      halted_reg <= halted_next;
      fault_reg  <= fault_next;
    end
  end

  assign pc       = pc_reg;
  assign i_datain = data_reg;
  assign i_valid  = valid_reg;
  assign halted   = halted_reg;
  assign fault    = fault_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: each scenario queues per-cycle stimulus
// with its expected outputs, then drives it and compares one cycle at a time.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int          DEPTH = 16;
  localparam int          AW    = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic          clock = 1'b0;
  logic          reset;
  logic          start, stall, redirect, load_en;
  logic [31:0]   redirect_pc, load_data;
  logic [AW-1:0] load_addr;
  logic [31:0]   i_datain, pc;
  logic          i_valid, halted, fault;

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .i_datain(i_datain),
    .pc(pc), .i_valid(i_valid), .halted(halted), .fault(fault)
  );

  always #5 clock = ~clock;

  // {pc, i_datain, i_valid, halted, fault}
  logic [66:0] obs;
  assign obs = {pc, i_datain, i_valid, halted, fault};

  typedef struct {
    logic          st, sl, rd, le;
    logic [31:0]   rpc, ld;
    logic [AW-1:0] la;
  } stim_t;

  logic [31:0] model [DEPTH];
  stim_t       stim_q[$];
  logic [66:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [66:0] e_run(input logic [31:0] a);
    return {a, model[a[AW+1:2]], 3'b100};
  endfunction
  function automatic logic [66:0] e_halt(input logic [31:0] a);
    return {a, 32'h0, 3'b010};
  endfunction
  function automatic logic [66:0] e_fault(input logic [31:0] a);
    return {a, 32'h0, 3'b001};
  endfunction
  function automatic logic [66:0] e_idle();
    return {RPC, 32'h0, 3'b000};
  endfunction

  task automatic add(input logic st, input logic sl, input logic rd,
                     input logic [31:0] rpc, input logic [66:0] ex);
    stim_t s;
    s.st = st; s.sl = sl; s.rd = rd; s.rpc = rpc; s.le = 1'b0; s.la = '0; s.ld = '0;
    stim_q.push_back(s);
    exp_q.push_back(ex);
  endtask

  // Queue a load cycle; the model only changes when the DUT is idle.
  task automatic add_load(input logic [AW-1:0] la, input logic [31:0] ld,
                          input logic st, input logic in_idle, input logic [66:0] ex);
    stim_t s;
    s.st = st; s.sl = 1'b0; s.rd = 1'b0; s.rpc = '0; s.le = 1'b1; s.la = la; s.ld = ld;
    stim_q.push_back(s);
    if (in_idle) model[la] = ld;
    exp_q.push_back(ex);
  endtask

  task automatic drive(input stim_t s);
    start = s.st; stall = s.sl; redirect = s.rd; redirect_pc = s.rpc;
    load_en = s.le; load_addr = s.la; load_data = s.ld;
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; redirect = 0; redirect_pc = 0;
    load_en = 0; load_addr = 0; load_data = 0;
  endtask

  task automatic test_reset();
    logic [66:0] e;
    idle_inputs();
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== e_idle()) begin
      n_errors++;
      $display("FAIL reset_values: got %h want %h", obs, e_idle());
    end
    start = 1'b1;
    @(posedge clock); @(negedge clock);
    n_checks++;
    if (obs !== e_idle()) begin
      n_errors++;
      $display("FAIL reset_holds: got %h want %h", obs, e_idle());
    end
    reset = 1'b0;
    start = 1'b0;
    add(0, 0, 0, 0, e_idle());
    add(0, 0, 0, 0, e_idle());
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clock); @(negedge clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL reset_idle: got %h want %h", obs, e);
      end
      $display("reset_idle: pc=%h data=%h vhf=%b", pc, i_datain, obs[2:0]);
    end
  endtask

  task automatic test_program();
    logic [66:0] e;
    add_load(0, 32'h8C01_0001, 0, 1, e_idle()); // lw gr1,1(gr0)
    add_load(1, 32'h8C02_0002, 0, 1, e_idle()); // lw gr2,2(gr0)
    add_load(2, 32'h0022_1820, 0, 1, e_idle()); // add gr3,gr1,gr2
    add_load(3, HALT_WORD, 0, 1, e_idle());
    for (int i = 4; i < DEPTH; i++) add_load(AW'(i), 32'hA000_0000 + 32'(i), 0, 1, e_idle());
    add(1, 0, 0, 0, e_run(32'h0));
    add(0, 0, 0, 0, e_run(32'h4));
    add(0, 0, 0, 0, e_run(32'h8));
    add(0, 0, 0, 0, e_halt(32'hC));
    add(1, 0, 1, 32'h10, e_halt(32'hC));
    add_load(4, 32'h5555_5555, 1, 0, e_halt(32'hC));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clock); @(negedge clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL program: got %h want %h", obs, e);
      end
      $display("program: pc=%h data=%h vhf=%b", pc, i_datain, obs[2:0]);
    end
    idle_inputs();
    reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== e_idle()) begin
      n_errors++;
      $display("FAIL reset_in_halt: got %h want %h", obs, e_idle());
    end
    reset = 1'b0;
  endtask

  task automatic test_redirect_stall();
    logic [66:0] e;
    add(1, 0, 0, 0, e_run(32'h0));
    add(0, 0, 1, 32'h20, e_run(32'h20));
    add(0, 0, 0, 0, e_run(32'h24));
    add(0, 0, 1, 32'h0, e_run(32'h0));
    add(0, 0, 0, 0, e_run(32'h4));
    add(0, 1, 0, 0, e_run(32'h4));
    add(0, 1, 0, 0, e_run(32'h4));
    add(0, 0, 0, 0, e_run(32'h8));
    add(0, 1, 1, 32'h20, e_run(32'h20));
    add(0, 0, 0, 0, e_run(32'h24));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clock); @(negedge clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL redirect_stall: got %h want %h", obs, e);
      end
      $display("redirect_stall: pc=%h data=%h vhf=%b", pc, i_datain, obs[2:0]);
    end
    idle_inputs();
    reset = 1'b1; #1; reset = 1'b0;
  endtask

  task automatic test_fault();
    logic [66:0] e;
    add(1, 0, 0, 0, e_run(32'h0));
    add(0, 0, 1, 32'h6, e_fault(32'h6));
    add(1, 0, 1, 32'h10, e_fault(32'h6));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clock); @(negedge clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL fault_misaligned: got %h want %h", obs, e);
      end
      $display("fault_misaligned: pc=%h data=%h vhf=%b", pc, i_datain, obs[2:0]);
    end
    idle_inputs();
    reset = 1'b1; #1; reset = 1'b0;
    add(1, 0, 0, 0, e_run(32'h0));
    add(0, 0, 1, 32'h10, e_run(32'h10));
    for (int a = 32'h14; a < 4 * DEPTH; a += 4) add(0, 0, 0, 0, e_run(32'(a)));
    add(0, 0, 0, 0, e_fault(32'(4 * DEPTH)));
    add(0, 0, 0, 0, e_fault(32'(4 * DEPTH)));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clock); @(negedge clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL fault_overflow: got %h want %h", obs, e);
      end
      $display("fault_overflow: pc=%h data=%h vhf=%b", pc, i_datain, obs[2:0]);
    end
    idle_inputs();
    reset = 1'b1; #1; reset = 1'b0;
  endtask

  task automatic test_load();
    logic [66:0] e;
    add_load(5, 32'h1234_5678, 1, 1, e_idle());
    add(0, 0, 0, 0, e_idle());
    add(1, 0, 0, 0, e_run(32'h0));
    add(0, 0, 1, 32'h14, e_run(32'h14));
    add_load(6, 32'hDEAD_BEEF, 0, 0, e_run(32'h18));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clock); @(negedge clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL load: got %h want %h", obs, e);
      end
      $display("load: pc=%h data=%h vhf=%b", pc, i_datain, obs[2:0]);
    end
    idle_inputs();
    reset = 1'b1; #1; reset = 1'b0;
    add(1, 0, 0, 0, e_run(32'h0));
    add(0, 0, 1, 32'h18, e_run(32'h18));
    add(0, 0, 1, 32'h14, e_run(32'h14));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clock); @(negedge clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL load_reread: got %h want %h", obs, e);
      end
      $display("load_reread: pc=%h data=%h vhf=%b", pc, i_datain, obs[2:0]);
    end
    idle_inputs();
    reset = 1'b1; #1; reset = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [66:0] e;
    add(1, 0, 0, 0, e_run(32'h0));
    add(0, 0, 0, 0, e_run(32'h4));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clock); @(negedge clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL mid_run_pre: got %h want %h", obs, e);
      end
      $display("mid_run_pre: pc=%h data=%h vhf=%b", pc, i_datain, obs[2:0]);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== e_idle()) begin
      n_errors++;
      $display("FAIL mid_run_async: got %h want %h", obs, e_idle());
    end
    $display("mid_run_async: pc=%h data=%h vhf=%b", pc, i_datain, obs[2:0]);
    #1 reset = 1'b0;
    add(0, 0, 0, 0, e_idle());
    add(0, 0, 0, 0, e_idle());
    add(1, 0, 0, 0, e_run(32'h0));
    add(0, 0, 0, 0, e_run(32'h4));
    add(0, 0, 0, 0, e_run(32'h8));
    add(0, 0, 0, 0, e_halt(32'hC));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      @(posedge clock); @(negedge clock);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_errors++;
        $display("FAIL mid_run_restart: got %h want %h", obs, e);
      end
      $display("mid_run_restart: pc=%h data=%h vhf=%b", pc, i_datain, obs[2:0]);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_program();
    test_redirect_stall();
    test_fault();
    test_load();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of the single-cycle `CPU` and drives its `i_datain` port. It holds a word-addressed instruction store that is loaded through a side port. After `start` it presents one instruction per cycle with its PC, advancing sequentially or jumping on a redirect from the CPU. It stops on the program-end sentinel `32'hFFFF_FFFF` and traps on illegal fetch addresses.

## Interface
Parameters:
- `DEPTH`, 64: instruction words in the store; power of two, 4..1024.
- `RESET_PC`, 32'h0000_0000: first fetch address; word-aligned, below 4*DEPTH.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; sampled in IDLE; begins fetching.
- `stall`  in  1  holds `pc`/`i_datain`/`i_valid` unchanged for the cycle.
- `redirect`  in  1  take `redirect_pc` as next fetch address (branch/jump).
- `redirect_pc`  in  32  byte address of redirect target.
- `load_en`  in  1  program-load write strobe; honoured in IDLE only.
- `load_addr`  in  $clog2(DEPTH)  word index written.
- `load_data`  in  32  instruction word written.
- `i_datain`  out  32  registered instruction to CPU.
- `pc`  out  32  byte address of `i_datain`.
- `i_valid`  out  1  `i_datain` is a live instruction.
- `halted`  out  1  sentinel reached; sticky.
- `fault`  out  1  illegal fetch address; sticky.

## Operation
- States: IDLE, RUN, HALT, FAULT. Reset enters IDLE.
- IDLE:
  - `load_en` writes `load_data` to word `load_addr` on the edge.
  - `start`=1 with `load_en`=0 -> RUN, and fetch `RESET_PC`.
  - `start` together with `load_en` is ignored. The write happens; `start` must still be high on a later cycle.
- RUN, each edge, priority redirect > stall > sequential:
  - next = `redirect` ? `redirect_pc` : `pc`+4.
  - `stall` without `redirect` holds all outputs.
- Fetch check on next:
  - next[1:0]≠0, or next≥4*DEPTH -> FAULT.
  - In FAULT: `i_valid`=0, `i_datain`=0, `fault`=1, `pc`=offending address.
  - No wrap-around: sequential overflow past the last word is a fault.
- Sentinel: a fetched word equal to `32'hFFFF_FFFF` -> HALT.
  - In HALT: `i_valid`=0, `i_datain`=0 (NOP), `halted`=1, `pc`=sentinel address.
  - The sentinel is never presented with `i_valid`=1.
- Otherwise: `pc`<=next, `i_datain`<=mem[next>>2], `i_valid`<=1.
- HALT and FAULT are terminal until `reset`. `start`, `load_en` and `redirect` are ignored there.
- `load_en` outside IDLE is ignored; memory is unchanged.
- Reset values: `i_datain`=0, `pc`=`RESET_PC`, `i_valid`=0, `halted`=0, `fault`=0, state IDLE.
- Memory contents are not reset and survive `reset`.

## Timing
- All outputs are registered and change only on a rising `clock` edge or on `reset` assertion.
- Start latency: `start` sampled at edge N -> `i_valid`=1 with mem[`RESET_PC`] after edge N.
- Sequential and redirect: one instruction per cycle with zero bubbles. A redirect sampled at edge N shows the target instruction after edge N.
- Stall: outputs held for exactly the stalled cycles. The CPU sees the same instruction again.
- Load: a write at edge N is readable by any fetch from edge N+1.
- Reset mid-RUN: outputs go to reset values asynchronously; fetch resumes only after a new `start`.
- Reset in HALT or FAULT: same behaviour, and the sticky flags are cleared.

## Structure
- Shared package `cpu_pkg`:
  - fetch state enum `fetch_state_t`.
  - `HALT_WORD`=32'hFFFF_FFFF.
  - `NOP_WORD`=32'h0000_0000.
  - `PC_STEP`=4.
- Sub-module `imem_array`: DEPTH×32 store with synchronous write and combinational read. `instr_fetch` registers the read data.
- `instr_fetch` holds the FSM, the address legality check and the output registers.

## Test plan
- Load words 0..2 = lw gr1,1(gr0); lw gr2,2(gr0); add gr3,gr1,gr2; word 3=`HALT_WORD`; pulse `start` -> `pc` 0,4,8 with those words and `i_valid`=1; next edge `halted`=1, `i_valid`=0, `pc`=12.
- Running from 0: `redirect`=1, `redirect_pc`=32'h20 at the second fetch -> next output `pc`=32'h20 with mem[8]; no bubble.
- `stall` high for 2 cycles at `pc`=4 -> `pc`=4 and its word held for 2 cycles; then `pc`=8. Repeat with `stall` and `redirect` both high -> redirect wins.
- `redirect_pc`=32'h6 -> `fault`=1, `pc`=6, `i_valid`=0. Sequential run off word DEPTH-1 -> `fault`=1, `pc`=4*DEPTH.
- `load_en`+`start` in the same IDLE cycle -> no fetch, and the word is written. `load_en` during RUN -> memory unchanged (reread after reset+start).
- Assert `reset` mid-RUN between edges -> outputs drop to reset values at once. Re-`start` -> fetch from `RESET_PC` with the program intact.
